decrypted_checker: RTL and testbench
====================================

// Module: decrypted_checker
// PURPOSE
//  Reader/validator for decrypted_memory, the read side of the PRGA decrypt writer.
//  - On a start pulse, streams MSG_LEN bytes out of decrypted_memory through its read port.
//  - Passes the message only if every byte is lowercase ASCII 'a'..'z' or a space.
//  - Reports pass/fail and the first failing index, then pulses finish; this drives key-search advance.
// PARAMETERS
//  MSG_LEN       32   bytes checked, addresses 0..MSG_LEN-1 (1..256)
//  ADDR_W        8    address width of decrypted_memory
//  DATA_W        8    data width of decrypted_memory
//  READ_LATENCY  1    cycles from address_d presented to q_d valid (1 or 2)
// PORTS
//  clk         in   1       system clock (CLOCK_50)
//  reset       in   1       asynchronous, active-low reset
//  start       in   1       1-cycle pulse; begin check (driven by PRGA finish)
//  q_d         in   DATA_W  read data from decrypted_memory
//  address_d   out  ADDR_W  read address to decrypted_memory
//  selector    out  1       high while this block owns the decrypted_memory port
//  busy        out  1       high from the cycle after start until the finish cycle inclusive
//  finish      out  1       1-cycle pulse; result valid from this cycle
//  valid       out  1       1 = all bytes legal; held until next accepted start
//  fail_index  out  ADDR_W  index of first illegal byte; 0 when valid=1
// BEHAVIOUR
//  - Reset (async, reset=0): state IDLE; all outputs 0, including address_d, valid and fail_index.
//  - Reset mid-run aborts the check; no finish is issued.
//  - Legal byte: 8'h61..8'h7A or 8'h20. All other values are illegal, including 8'h60, 8'h7B and 8'h00.
//  - FSM: IDLE -> READ -> DRAIN -> DONE -> IDLE.
//  - IDLE: start=1 is accepted and valid/fail_index are cleared. Any start seen while busy is ignored.
//  - READ: one address per cycle.
//    - Cycle 0 is the start cycle; address_d=k in cycle k+1.
//    - After MSG_LEN-1 has been issued, go to DRAIN.
//    - address_d is held at its last value outside READ.
//  - Read pipeline: a tag {vld, idx} shift register of depth READ_LATENCY marks which cycles carry q_d for byte idx.
//  - Byte k is compared in cycle k+1+READ_LATENCY, and the compare result is registered.
//  - First illegal byte k:
//    - Stop issuing addresses and discard in-flight tags.
//    - Set fail_index=k, valid=0, go to DONE.
//    - finish is high in cycle k+READ_LATENCY+2.
//  - All bytes legal:
//    - Set valid=1, fail_index=0.
//    - finish is high in cycle MSG_LEN+READ_LATENCY+1.
//  - DONE: finish=1 for exactly one cycle, then IDLE.
//    - start in the DONE cycle is ignored.
//    - start in the following cycle is accepted.
//  - selector=1 in READ, DRAIN and DONE; 0 in IDLE. The top-level mux uses it to grant the port.
//  - Index counter is ADDR_W+1 bits so MSG_LEN=256 terminates without wrap; address_d takes the low ADDR_W bits.
//  - No write port: this block never writes decrypted_memory.
// STRUCTURE
//  - rc4_pkg holds:
//    - chk_state_t enum {IDLE, READ, DRAIN, DONE}
//    - CHAR_SPACE=8'h20, CHAR_LO=8'h61, CHAR_HI=8'h7A
//    - function is_legal_char(byte)
//    - DEFAULT_MSG_LEN=32
//  - One sub-module, read_tag_pipe (params DEPTH, IDX_W):
//    - Delays {vld, idx} to align with q_d.
//    - flush input clears all vld bits.
//    - Has its own clk and async active-low reset.
// TESTING
//  - All bytes 8'h61 -> finish at cycle MSG_LEN+L+1, valid=1, fail_index=0; exactly one finish pulse.
//  - Mix with 8'h20 at idx 5, 8'h7A at idx 6 -> valid=1.
//  - 8'h41 at idx 7 -> finish at cycle 9+L, valid=0, fail_index=7; address_d never exceeds 7+L.
//  - Boundaries at idx 0 and idx 31:
//    - 8'h60 at idx 0 -> fail_index=0.
//    - 8'h7B at idx 31 -> fail_index=31.
//    - 8'h00 at idx 31 -> fail_index=31.
//  - Extra start pulses during READ and in the DONE cycle -> ignored, single finish.
//    - Next start after DONE -> valid/fail_index cleared, full re-run.
//  - reset=0 at cycle 10 of a run -> all outputs 0 immediately, no finish.
//    - After release, a fresh start yields a correct result.
//  - Repeat the suite at READ_LATENCY=2 and MSG_LEN=256 (fail at idx 255 -> fail_index=255).

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and character rules for the decrypted-message checker.
package rc4_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_LO    = 8'h61;
  localparam logic [7:0] CHAR_HI    = 8'h7A;

  localparam int DEFAULT_MSG_LEN = 32;

  function automatic logic is_legal_char(input logic [7:0] b);
    return ((b >= CHAR_LO) && (b <= CHAR_HI)) || (b == CHAR_SPACE);
  endfunction

endpackage

// File: rtl/read_tag_pipe.sv
// Delays a {vld, idx} tag by DEPTH cycles so it lines up with memory read data.
module read_tag_pipe #(
  parameter int DEPTH = 1,
  parameter int IDX_W = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             vld_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic             vld_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [DEPTH-1:0]            vld_pipe;
  logic [DEPTH-1:0][IDX_W-1:0] idx_pipe;

  // flush also drops the tag entering this cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      for (int s = DEPTH - 1; s > 0; s--) begin
        vld_pipe[s] <= vld_pipe[s-1] & ~flush_i;
        idx_pipe[s] <= idx_pipe[s-1];
      end
      vld_pipe[0] <= vld_i & ~flush_i;
      idx_pipe[0] <= idx_i;
    end
  end

  assign vld_o = vld_pipe[DEPTH-1];
  assign idx_o = idx_pipe[DEPTH-1];

endmodule

// File: rtl/decrypted_checker.sv
// Streams MSG_LEN bytes out of decrypted_memory and flags the first byte that
// is not lowercase ASCII or space.
module decrypted_checker
  import rc4_pkg::*;
#(
  parameter int MSG_LEN      = DEFAULT_MSG_LEN,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] q_d,
  output logic [ADDR_W-1:0] address_d,
  output logic              selector,
  output logic              busy,
  output logic              finish,
  output logic              valid,
  output logic [ADDR_W-1:0] fail_index
);

  // one extra bit so MSG_LEN = 2**ADDR_W never wraps
  localparam int              CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MSG_LEN - 1);

  chk_state_t        state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] fail_q, fail_d;

  logic              tag_vld;
  logic [CNT_W-1:0]  tag_idx;
  logic              flush;
  logic              byte_bad;
  logic              byte_last;

  read_tag_pipe #(
    .DEPTH (READ_LATENCY),
    .IDX_W (CNT_W)
  ) u_tag_pipe (
    .clk_i   (clk),
    .rst_ni  (reset),
    .flush_i (flush),
    .vld_i   (state_q == READ),
    .idx_i   (idx_q),
    .vld_o   (tag_vld),
    .idx_o   (tag_idx)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    fail_d    = fail_q;
    flush     = 1'b0;
    byte_bad  = tag_vld && !is_legal_char(q_d[7:0]);
    byte_last = tag_vld && (tag_idx == LAST_IDX);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          idx_d   = '0;
          valid_d = 1'b0;
          fail_d  = '0;
        end
      end
      READ, DRAIN: begin
        if (byte_bad) begin
          state_d = DONE;
          valid_d = 1'b0;
          fail_d  = tag_idx[ADDR_W-1:0];
          flush   = 1'b1;
        end else if (byte_last) begin
          state_d = DONE;
          valid_d = 1'b1;
          fail_d  = '0;
          flush   = 1'b1;
        end else if (state_q == READ) begin
          if (idx_q == LAST_IDX) state_d = DRAIN;
          else                   idx_d   = idx_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      fail_q  <= fail_d;
    end
  end

  assign address_d  = idx_q[ADDR_W-1:0];
  assign selector   = (state_q != IDLE);
  assign busy       = (state_q != IDLE);
  assign finish     = (state_q == DONE);
  assign valid      = valid_q;
  assign fail_index = fail_q;

endmodule

// File: tb/tb_decrypted_checker.sv
// Two checkers (32 bytes / latency 1 and 256 bytes / latency 2) share one
// memory image and one start; each is compared every cycle to a result model.
module tb_decrypted_checker;

  logic clk = 1'b0;
  logic reset;
  logic start;
  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic [7:0] q_w [2];
  logic [7:0] addr_w [2];
  logic [7:0] fidx_w [2];
  logic       busy_w [2];
  logic       sel_w [2];
  logic       fin_w [2];
  logic       val_w [2];

  int n_tests = 0;
  int n_fail  = 0;

  // model state per checker
  bit   m_run [2];
  int   m_t [2];
  int   m_fin [2];
  int   m_cap [2];
  bit   m_rv [2];
  int   m_rf [2];
  int   e_addr [2];
  bit   e_v [2];
  int   e_f [2];

  // hand-computed literal expectations for the current run
  bit pin_en [2];
  int pin_fin [2];
  bit pin_v [2];
  int pin_f [2];

  function automatic int mlen(int g);
    return (g == 0) ? 32 : 256;
  endfunction

  function automatic int lat(int g);
    return (g == 0) ? 1 : 2;
  endfunction

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic bit legal(logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int M = (g == 0) ? 32 : 256;
    localparam int L = (g == 0) ? 1 : 2;
    logic [7:0] rd0, rd1;
    always @(posedge clk) begin
      rd0 <= mem[addr_w[g]];
      rd1 <= rd0;
    end
    assign q_w[g] = (L == 1) ? rd0 : rd1;

    decrypted_checker #(
      .MSG_LEN      (M),
      .ADDR_W       (8),
      .DATA_W       (8),
      .READ_LATENCY (L)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .q_d        (q_w[g]),
      .address_d  (addr_w[g]),
      .selector   (sel_w[g]),
      .busy       (busy_w[g]),
      .finish     (fin_w[g]),
      .valid      (val_w[g]),
      .fail_index (fidx_w[g])
    );
  end

  task automatic chk(string nm, int g, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0d got=%0d exp=%0d", nm, g, m_t[g], got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!reset) begin
        m_run[g]  = 1'b0;
        m_t[g]    = 0;
        e_addr[g] = 0;
        e_v[g]    = 1'b0;
        e_f[g]    = 0;
      end else if (m_run[g]) begin
        e_addr[g] = imin(m_t[g] - 1, imin(mlen(g) - 1, m_cap[g]));
        if (m_t[g] == m_fin[g]) begin
          e_v[g] = m_rv[g];
          e_f[g] = m_rf[g];
        end
      end
      chk("busy",       g, int'(busy_w[g]), int'(m_run[g]));
      chk("selector",   g, int'(sel_w[g]),  int'(m_run[g]));
      chk("finish",     g, int'(fin_w[g]),  int'(m_run[g] && (m_t[g] == m_fin[g])));
      chk("valid",      g, int'(val_w[g]),  int'(e_v[g]));
      chk("fail_index", g, int'(fidx_w[g]), e_f[g]);
      chk("address_d",  g, int'(addr_w[g]), e_addr[g]);
      if (reset && m_run[g] && pin_en[g] && (m_t[g] == pin_fin[g])) begin
        chk("pin_finish",     g, int'(fin_w[g]),  1);
        chk("pin_valid",      g, int'(val_w[g]),  int'(pin_v[g]));
        chk("pin_fail_index", g, int'(fidx_w[g]), pin_f[g]);
      end
      if (reset) begin
        if (m_run[g]) begin
          if (m_t[g] == m_fin[g]) m_run[g] = 1'b0;
          else                    m_t[g]++;
        end else if (start) begin
          int k;
          k = -1;
          for (int i = 0; i < mlen(g); i++)
            if (k < 0 && !legal(mem[i])) k = i;
          m_run[g] = 1'b1;
          m_t[g]   = 1;
          e_v[g]   = 1'b0;
          e_f[g]   = 0;
          if (k >= 0) begin
            m_fin[g] = k + lat(g) + 2;
            m_rv[g]  = 1'b0;
            m_rf[g]  = k;
            m_cap[g] = k + lat(g);
          end else begin
            m_fin[g] = mlen(g) + lat(g) + 1;
            m_rv[g]  = 1'b1;
            m_rf[g]  = 0;
            m_cap[g] = mlen(g) - 1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic fill_a();
    for (int i = 0; i < 256; i++) mem[i] = 8'h61;
  endtask

  task automatic set_pins(input int f0, input bit v0, input int x0,
                          input int f1, input bit v1, input int x1);
    pin_en[0] = 1'b1; pin_fin[0] = f0; pin_v[0] = v0; pin_f[0] = x0;
    pin_en[1] = 1'b1; pin_fin[1] = f1; pin_v[1] = v1; pin_f[1] = x1;
  endtask

  task automatic no_pins();
    pin_en[0] = 1'b0;
    pin_en[1] = 1'b0;
  endtask

  task automatic run();
    pulse();
    repeat (264) tick();
  endtask

  function automatic logic [7:0] bad_char();
    case ($urandom_range(0, 5))
      0:       return 8'h60;
      1:       return 8'h7B;
      2:       return 8'h00;
      3:       return 8'h41;
      4:       return 8'h1F;
      default: return 8'h21;
    endcase
  endfunction

  initial begin
    reset = 1'b0;
    start = 1'b0;
    no_pins();
    fill_a();
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();

    fill_a();
    set_pins(34, 1, 0, 259, 1, 0);
    run();

    fill_a(); mem[5] = 8'h20; mem[6] = 8'h7A;
    set_pins(34, 1, 0, 259, 1, 0);
    run();

    fill_a(); mem[7] = 8'h41;
    set_pins(10, 0, 7, 11, 0, 7);
    run();

    fill_a(); mem[0] = 8'h60;
    set_pins(3, 0, 0, 4, 0, 0);
    run();

    fill_a(); mem[31] = 8'h7B;
    set_pins(34, 0, 31, 35, 0, 31);
    run();

    fill_a(); mem[31] = 8'h00;
    set_pins(34, 0, 31, 35, 0, 31);
    run();

    fill_a(); mem[255] = 8'h00;
    set_pins(34, 1, 0, 259, 0, 255);
    run();

    no_pins();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 256; i++) begin
        int c;
        c = $urandom_range(0, 26);
        mem[i] = (c == 26) ? 8'h20 : 8'(8'h61 + c);
        if ($urandom_range(0, 199) == 0) mem[i] = 8'($urandom);
      end
      if ($urandom_range(0, 1) == 1) mem[$urandom_range(0, 40)] = bad_char();
      run();
    end

    // extra starts: mid-READ, in dut0's DONE cycle, then the cycle after
    fill_a();
    set_pins(34, 1, 0, 259, 1, 0);
    pulse();
    repeat (4) tick();
    pulse();
    repeat (28) tick();
    pulse();
    pulse();
    repeat (300) tick();

    // reset in cycle 10 of a run, then a clean run
    no_pins();
    fill_a();
    pulse();
    repeat (9) tick();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    fill_a(); mem[20] = 8'h7B;
    set_pins(23, 0, 20, 24, 0, 20);
    run();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
